// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared definitions for the issue-stage controller.
// Carries the FSM state encodings, the register-reference bundle used by
// the scoreboard, and small helpers for one-hot register decode.
// Also provides fallback zone definitions when the shared RISC-V
// definitions have not already been seen by the compiler.
// Optional feature macro used by this slice: ISSUE_WB_BYPASS_EN.

`ifndef ZONE_RANGE
`define ZONE_RANGE 2:0
`endif
`ifndef ZONE_LOADQ
`define ZONE_LOADQ 3'd2
`endif

package issue_ctrl_pkg;

    // Controller states, kept as plain constants for legacy tool flows.
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_ERR  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Architectural integer register count tracked by the scoreboard.
    localparam int unsigned C_NREGS = 32;

    // One register operand as seen by the hazard check: used flag plus index.
    typedef struct packed {
        logic       used;
        logic [4:0] addr;
    } reg_ref_t;

    // One-hot decode of a register index.
    function automatic logic [C_NREGS-1:0] reg_onehot(input logic [4:0] idx);
        logic [C_NREGS-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Hazard contribution of a single operand; x0 never carries a hazard.
    function automatic logic ref_hazard(input reg_ref_t r,
                                        input logic [C_NREGS-1:0] pend);
        return r.used & (r.addr != 5'd0) & pend[r.addr];
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: pending-load scoreboard for the issue stage.
// Tracks which registers have an outstanding load, how many loads are in
// flight, and reports whether the presented instruction hits a pending
// register. With ISSUE_WB_BYPASS_EN defined, a writeback in the current
// cycle is already visible to the hazard check; otherwise the check only
// sees the registered pending vector.

import issue_ctrl_pkg::*;

module issue_scoreboard #(
    parameter int C_LQ_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       resetb_i,
    input  reg_ref_t   rs1_i,
    input  reg_ref_t   rs2_i,
    input  reg_ref_t   rd_i,
    input  logic       set_i,
    input  logic [4:0] set_addr_i,
    input  logic       wb_valid_i,
    input  logic [4:0] wb_addr_i,
    output logic       hazard_o,
    output logic       lq_full_o,
    output logic       lq_empty_o,
    output logic       lq_busy_o
);

    localparam int CW = $clog2(C_LQ_DEPTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(C_LQ_DEPTH);

    logic [C_NREGS-1:0] pend_q, pend_d;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q;
    logic               wbEff;
    logic [C_NREGS-1:0] pendView;

    // A writeback with nothing outstanding is a no-op, so it neither clears
    // nor decrements.
    assign wbEff = wb_valid_i & (count_q != '0);

`ifdef ISSUE_WB_BYPASS_EN
    // The retiring register is treated as already free for this cycle's check.
    assign pendView = pend_q & ~(wbEff ? reg_onehot(wb_addr_i) : '0);
`else
    // Hazard check sees only the registered state; a retiring load still
    // blocks its dependants for the writeback cycle itself.
    assign pendView = pend_q;
`endif

    assign hazard_o   = ref_hazard(rs1_i, pendView)
                      | ref_hazard(rs2_i, pendView)
                      | ref_hazard(rd_i,  pendView);
    assign lq_full_o  = (count_q == C_FULL);
    assign lq_empty_o = (count_q == '0);
    assign lq_busy_o  = busy_q;

    // Next pending vector and load count: clear first so a same-index set
    // in the same cycle wins; set and retire together leave the count as is.
    always_comb begin
        pend_d  = pend_q;
        count_d = count_q;
        if (wbEff) begin
            pend_d = pend_d & ~reg_onehot(wb_addr_i);
        end
        if (set_i && (set_addr_i != 5'd0)) begin
            pend_d = pend_d | reg_onehot(set_addr_i);
        end
        pend_d[0] = 1'b0;
        case ({set_i, wbEff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Scoreboard registers; busy is registered from the next count so it
    // tracks the count with no combinational path to the output.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            pend_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            count_q <= count_d;
            busy_q  <= (count_d != '0);
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: issue-stage controller between decode and execute.
// Accepts one decoded instruction per cycle into a single output register,
// stalls on hazards against outstanding loads, serialises CSR accesses
// behind a drained pipeline, and on an illegal instruction pulses excep_o
// and halts until a flush.
// Optional feature macro: ISSUE_WB_BYPASS_EN (writeback bypass into the
// hazard check, implemented inside issue_scoreboard).

`ifndef ZONE_RANGE
`define ZONE_RANGE 2:0
`endif
`ifndef ZONE_LOADQ
`define ZONE_LOADQ 3'd2
`endif

import issue_ctrl_pkg::*;

module issue_ctrl #(
    parameter int C_LQ_DEPTH  = 4,
    parameter int C_PAYLOAD_W = 64
) (
    input  logic                   clk_i,
    input  logic                   resetb_i,
    input  logic                   ids_valid_i,
    output logic                   ids_ready_o,
    input  logic [C_PAYLOAD_W-1:0] ids_payload_i,
    input  logic                   ins_err_i,
    input  logic [`ZONE_RANGE]     zone_i,
    input  logic                   regd_tgt_i,
    input  logic [4:0]             regd_addr_i,
    input  logic                   regs1_rd_i,
    input  logic [4:0]             regs1_addr_i,
    input  logic                   regs2_rd_i,
    input  logic [4:0]             regs2_addr_i,
    input  logic                   csr_rd_i,
    input  logic                   csr_wr_i,
    output logic                   exs_valid_o,
    input  logic                   exs_ready_i,
    output logic [C_PAYLOAD_W-1:0] exs_payload_o,
    input  logic                   lq_wb_valid_i,
    input  logic [4:0]             lq_wb_addr_i,
    input  logic                   flush_i,
    output logic                   excep_o,
    output logic                   lq_busy_o
);

    generate
        if (C_LQ_DEPTH < 1) begin : g_bad_depth
            $error("issue_ctrl: C_LQ_DEPTH must be at least 1");
        end
    endgenerate

    logic [1:0]             state_q, state_d;
    logic                   exs_valid_q, exs_valid_d;
    logic [C_PAYLOAD_W-1:0] exs_payload_q, exs_payload_d;

    logic isLoad;
    logic isCsr;
    logic space;
    logic hazard;
    logic lqFull;
    logic lqEmpty;
    logic idsReady;
    logic accept;
    logic acceptIns;
    logic acceptErr;
    logic loadSet;

    assign isLoad = (zone_i == `ZONE_LOADQ);
    assign isCsr  = csr_rd_i | csr_wr_i;
    assign space  = ~exs_valid_q | exs_ready_i;

    issue_scoreboard #(
        .C_LQ_DEPTH (C_LQ_DEPTH)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .resetb_i   (resetb_i),
        .rs1_i      ('{used: regs1_rd_i, addr: regs1_addr_i}),
        .rs2_i      ('{used: regs2_rd_i, addr: regs2_addr_i}),
        .rd_i       ('{used: regd_tgt_i, addr: regd_addr_i}),
        .set_i      (loadSet),
        .set_addr_i (regd_addr_i),
        .wb_valid_i (lq_wb_valid_i),
        .wb_addr_i  (lq_wb_addr_i),
        .hazard_o   (hazard),
        .lq_full_o  (lqFull),
        .lq_empty_o (lqEmpty),
        .lq_busy_o  (lq_busy_o)
    );

    // Ready decision: only RUN accepts, never during a flush. An illegal
    // instruction only needs a free output slot since it is never forwarded;
    // CSR accesses wait for no loads in flight and an empty output register.
    always_comb begin
        idsReady = 1'b0;
        if (!flush_i && (state_q == ST_RUN)) begin
            if (ids_valid_i && ins_err_i) begin
                idsReady = space;
            end else begin
                idsReady = space
                         & ~hazard
                         & ~(isLoad & lqFull)
                         & ~(isCsr & (~lqEmpty | exs_valid_q));
            end
        end
    end

    assign ids_ready_o = idsReady;
    assign accept      = ids_valid_i & idsReady;
    assign acceptIns   = accept & ~ins_err_i;
    assign acceptErr   = accept & ins_err_i;
    assign loadSet     = acceptIns & isLoad & regd_tgt_i;

    // Controller FSM: an accepted illegal instruction spends one cycle in ERR
    // (the exception pulse) and then parks in HALT until flushed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (acceptErr) state_d = ST_ERR;
            ST_ERR:  state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
        if (flush_i) begin
            state_d = ST_RUN;
        end
    end

    // Output register: flush empties it, an accepted legal instruction
    // refills it, otherwise it drains when execute consumes. The payload is
    // held after draining so it only changes on a new issue.
    always_comb begin
        exs_valid_d   = exs_valid_q;
        exs_payload_d = exs_payload_q;
        if (flush_i) begin
            exs_valid_d = 1'b0;
        end else if (acceptIns) begin
            exs_valid_d   = 1'b1;
            exs_payload_d = ids_payload_i;
        end else if (exs_ready_i) begin
            exs_valid_d = 1'b0;
        end
    end

    // State and output register update.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q       <= ST_RUN;
            exs_valid_q   <= 1'b0;
            exs_payload_q <= '0;
        end else begin
            state_q       <= state_d;
            exs_valid_q   <= exs_valid_d;
            exs_payload_q <= exs_payload_d;
        end
    end

    assign exs_valid_o   = exs_valid_q;
    assign exs_payload_o = exs_payload_q;
    assign excep_o       = (state_q == ST_ERR);

endmodule
